// File: rtl/bls12_381_fe12_stream_tx.sv
// Serialises one FE12 element (12 Fp coefficients) into a 12-beat sop/eop stream packet.
// Optional macro BLS12_381_FE12_STREAM_TX_SKID_EN adds a second element register for gapless packets.
module bls12_381_fe12_stream_tx #(
   parameter int FE_BITS   = 381,
   parameter int CTL_BITS  = 8,
   parameter int BEAT_BYTS = 48
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_fe12_val,
   input  logic [12*FE_BITS-1:0]        i_fe12_dat,
   input  logic [CTL_BITS-1:0]          i_fe12_ctl,
   output logic                         o_fe12_rdy,
   output logic                         o_stream_val,
   output logic [BEAT_BYTS*8-1:0]       o_stream_dat,
   output logic                         o_stream_sop,
   output logic                         o_stream_eop,
   output logic [CTL_BITS-1:0]          o_stream_ctl,
   output logic [$clog2(BEAT_BYTS)-1:0] o_stream_mod,
   output logic                         o_stream_err,
   input  logic                         i_stream_rdy
);

   localparam int NUM_FE   = 12;
   localparam int EW       = NUM_FE*FE_BITS;
   localparam int DAT_BITS = BEAT_BYTS*8;
   localparam logic [3:0] LAST = 4'd11;

   typedef enum logic {IDLE, SEND} state_t;

   state_t               state, state_nxt;
   logic [3:0]           cnt, cnt_nxt;
   logic [EW-1:0]        act_dat, act_dat_nxt;
   logic [CTL_BITS-1:0]  act_ctl, act_ctl_nxt;
   logic                 val_nxt, sop_nxt, eop_nxt, rdy_nxt;
   logic [DAT_BITS-1:0]  dat_nxt;
   logic [CTL_BITS-1:0]  ctl_nxt;
   logic                 acc, hs, ld;
   logic [EW-1:0]        ld_dat;
   logic [CTL_BITS-1:0]  ld_ctl;
`ifdef BLS12_381_FE12_STREAM_TX_SKID_EN
   logic                 sk_full, sk_full_nxt;
   logic [EW-1:0]        sk_dat, sk_dat_nxt;
   logic [CTL_BITS-1:0]  sk_ctl, sk_ctl_nxt;
`endif

   // Coefficient idx, zero-extended to the beat width; values >= P pass through untouched.
   function automatic logic [DAT_BITS-1:0] coef(input logic [EW-1:0] src, input logic [3:0] idx);
      logic [DAT_BITS-1:0] res;
      res = '0;
      for (int n = 0; n < NUM_FE; n++)
         if (idx == 4'(n)) res[FE_BITS-1:0] = src[n*FE_BITS +: FE_BITS];
      return res;
   endfunction

   assign acc          = i_fe12_val & o_fe12_rdy;
   assign hs           = o_stream_val & i_stream_rdy;
   assign o_stream_mod = '0;
   assign o_stream_err = 1'b0;

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      act_dat_nxt = act_dat;
      act_ctl_nxt = act_ctl;
      val_nxt     = o_stream_val;
      dat_nxt     = o_stream_dat;
      sop_nxt     = o_stream_sop;
      eop_nxt     = o_stream_eop;
      ctl_nxt     = o_stream_ctl;
      ld          = 1'b0;
      ld_dat      = i_fe12_dat;
      ld_ctl      = i_fe12_ctl;
`ifdef BLS12_381_FE12_STREAM_TX_SKID_EN
      sk_full_nxt = sk_full;
      sk_dat_nxt  = sk_dat;
      sk_ctl_nxt  = sk_ctl;
`endif
      case (state)
         IDLE: ld = acc;
         SEND: begin
            if (hs && cnt == LAST) begin
`ifdef BLS12_381_FE12_STREAM_TX_SKID_EN
               if (sk_full) begin
                  ld          = 1'b1;
                  ld_dat      = sk_dat;
                  ld_ctl      = sk_ctl;
                  sk_full_nxt = 1'b0;
               end else begin
                  ld = acc;
               end
`endif
               if (!ld) begin
                  state_nxt = IDLE;
                  cnt_nxt   = 4'd0;
                  val_nxt   = 1'b0;
                  sop_nxt   = 1'b0;
                  eop_nxt   = 1'b0;
               end
            end else if (hs) begin
               cnt_nxt = cnt + 4'd1;
               dat_nxt = coef(act_dat, cnt + 4'd1);
               sop_nxt = 1'b0;
               eop_nxt = (cnt == LAST - 4'd1);
            end
`ifdef BLS12_381_FE12_STREAM_TX_SKID_EN
            // An element arriving mid-packet parks in the skid entry unless it was loaded directly.
            if (acc && !ld) begin
               sk_full_nxt = 1'b1;
               sk_dat_nxt  = i_fe12_dat;
               sk_ctl_nxt  = i_fe12_ctl;
            end
`endif
         end
         default: state_nxt = IDLE;
      endcase
      if (ld) begin
         state_nxt   = SEND;
         cnt_nxt     = 4'd0;
         act_dat_nxt = ld_dat;
         act_ctl_nxt = ld_ctl;
         val_nxt     = 1'b1;
         dat_nxt     = coef(ld_dat, 4'd0);
         sop_nxt     = 1'b1;
         eop_nxt     = 1'b0;
         ctl_nxt     = ld_ctl;
      end
`ifdef BLS12_381_FE12_STREAM_TX_SKID_EN
      rdy_nxt = !sk_full_nxt;
`else
      rdy_nxt = (state_nxt == IDLE);
`endif
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state        <= IDLE;
         cnt          <= 4'd0;
         o_stream_val <= 1'b0;
         o_stream_dat <= '0;
         o_stream_sop <= 1'b0;
         o_stream_eop <= 1'b0;
         o_stream_ctl <= '0;
         o_fe12_rdy   <= 1'b0;
`ifdef BLS12_381_FE12_STREAM_TX_SKID_EN
         sk_full      <= 1'b0;
`endif
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         o_stream_val <= val_nxt;
         o_stream_dat <= dat_nxt;
         o_stream_sop <= sop_nxt;
         o_stream_eop <= eop_nxt;
         o_stream_ctl <= ctl_nxt;
         o_fe12_rdy   <= rdy_nxt;
`ifdef BLS12_381_FE12_STREAM_TX_SKID_EN
         sk_full      <= sk_full_nxt;
`endif
      end
   end

   // Element storage needs no reset: it is only read while a valid flag says it is live.
   always_ff @(posedge i_clk) begin
      act_dat <= act_dat_nxt;
      act_ctl <= act_ctl_nxt;
`ifdef BLS12_381_FE12_STREAM_TX_SKID_EN
      sk_dat  <= sk_dat_nxt;
      sk_ctl  <= sk_ctl_nxt;
`endif
   end

endmodule

// File: tb/tb_bls12_381_fe12_stream_tx.sv
// Directed bench for bls12_381_fe12_stream_tx: element table plus backpressure, back-to-back and reset sequences.
module tb_bls12_381_fe12_stream_tx;

   localparam logic [380:0] P_MOD = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;
`ifdef BLS12_381_FE12_STREAM_TX_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   typedef struct {
      logic [11:0][380:0] coef;
      logic [7:0]         ctl;
      logic [11:0][383:0] exp_dat;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              fe_val;
   logic [12*381-1:0] fe_dat;
   logic [7:0]        fe_ctl;
   logic              fe_rdy;
   logic              s_val, s_sop, s_eop, s_err, s_rdy;
   logic [383:0]      s_dat;
   logic [7:0]        s_ctl;
   logic [5:0]        s_mod;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   vec_t               vecs[4];
   logic [11:0][380:0] bp;
   logic [383:0]       got[12];

   bls12_381_fe12_stream_tx dut (
      .i_clk(clk), .i_rst(rst), .i_fe12_val(fe_val), .i_fe12_dat(fe_dat), .i_fe12_ctl(fe_ctl),
      .o_fe12_rdy(fe_rdy), .o_stream_val(s_val), .o_stream_dat(s_dat), .o_stream_sop(s_sop),
      .o_stream_eop(s_eop), .o_stream_ctl(s_ctl), .o_stream_mod(s_mod), .o_stream_err(s_err),
      .i_stream_rdy(s_rdy)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic chki(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", nm, act, exp);
      end
   endtask

   // Returns in the cycle right after the accepting edge, where beat 0 must already be visible.
   task automatic send_elem(input logic [11:0][380:0] c, input logic [7:0] ctl);
      int w;
      fe_dat = c;
      fe_ctl = ctl;
      fe_val = 1'b1;
      w = 0;
      while (!fe_rdy && w < 50) begin
         step;
         w++;
      end
      chki("accept_wait", 32'(w < 50), 32'd1);
      step;
      fe_val = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int hs, acc1, acc2, sop1, sop2, eop1, eop2, nacc;
      logic         pv, pr, ps, pe;
      logic [383:0] pd;
      logic [7:0]   pc, ctl_eop1, ctl_sop2;

      rst = 1'b0; fe_val = 1'b0; fe_dat = '0; fe_ctl = '0; s_rdy = 1'b1;

      for (int n = 0; n < 12; n++) begin
         vecs[0].coef[n]    = 381'(n + 1);
         vecs[0].exp_dat[n] = 384'(n + 1);
         vecs[1].coef[n]    = (n == 0) ? {381{1'b1}} : (381'(n) << 200);
         vecs[1].exp_dat[n] = (n == 0) ? {3'b000, {381{1'b1}}} : (384'(n) << 200);
         vecs[2].coef[n]    = (n == 0) ? P_MOD : (n == 1) ? P_MOD - 381'd1 : (381'd1 << (n*31));
         vecs[2].exp_dat[n] = (n == 0) ? {3'b000, P_MOD} : (n == 1) ? {3'b000, P_MOD} - 384'd1 : (384'd1 << (n*31));
         vecs[3].coef[n]    = {8'(n + 1), 373'h0};
         vecs[3].exp_dat[n] = {3'b000, 8'(n + 1), 373'h0};
         bp[n]              = P_MOD - 381'(n*7919 + 1);
      end
      vecs[0].ctl = 8'hA5; vecs[1].ctl = 8'h11; vecs[2].ctl = 8'h7E; vecs[3].ctl = 8'h5A;

      // reset state
      for (int i = 0; i < 2; i++) begin
         step;
         chki("rst_val", 32'(s_val), 0); chki("rst_rdy", 32'(fe_rdy), 0);
         chki("rst_sop", 32'(s_sop), 0); chki("rst_eop", 32'(s_eop), 0);
         chk("rst_dat", s_dat, '0);      chki("rst_ctl", 32'(s_ctl), 0);
      end
      rst = 1'b1;
      step;
      chki("rdy_after_rst", 32'(fe_rdy), 1);

      // table: one element each, rdy high, 12 consecutive beats
      for (int v = 0; v < 4; v++) begin
         send_elem(vecs[v].coef, vecs[v].ctl);
         for (int b = 0; b < 12; b++) begin
            chki($sformatf("v%0d_b%0d_val", v, b), 32'(s_val), 1);
            chk($sformatf("v%0d_b%0d_dat", v, b), s_dat, vecs[v].exp_dat[b]);
            chki($sformatf("v%0d_b%0d_sop", v, b), 32'(s_sop), 32'(b == 0));
            chki($sformatf("v%0d_b%0d_eop", v, b), 32'(s_eop), 32'(b == 11));
            chki($sformatf("v%0d_b%0d_ctl", v, b), 32'(s_ctl), 32'(vecs[v].ctl));
            if (b == 0) begin
               chki("mod", 32'(s_mod), 0); chki("err", 32'(s_err), 0);
               chki("rdy_in_send", 32'(fe_rdy), 32'(SKID));
            end
            step;
         end
         chki($sformatf("v%0d_end_val", v), 32'(s_val), 0);
         chki($sformatf("v%0d_end_rdy", v), 32'(fe_rdy), 1);
      end

      // backpressure: rdy pattern 1,0,0 repeating
      send_elem(bp, 8'h3C);
      hs = 0; pv = 0; pr = 1; pd = '0; ps = 0; pe = 0; pc = '0;
      for (int c = 0; c < 100 && hs < 12; c++) begin
         s_rdy = (c % 3 == 0);
         if (pv && !pr) begin
            chk("bp_hold_dat", s_dat, pd); chki("bp_hold_sop", 32'(s_sop), 32'(ps));
            chki("bp_hold_eop", 32'(s_eop), 32'(pe)); chki("bp_hold_ctl", 32'(s_ctl), 32'(pc));
         end
         chki("bp_val", 32'(s_val), 1);
         if (s_val && s_rdy) begin
            got[hs] = s_dat;
            chki("bp_sop", 32'(s_sop), 32'(hs == 0));
            chki("bp_eop", 32'(s_eop), 32'(hs == 11));
            hs++;
         end
         pv = s_val; pr = s_rdy; pd = s_dat; ps = s_sop; pe = s_eop; pc = s_ctl;
         step;
      end
      s_rdy = 1'b1;
      chki("bp_handshakes", 32'(hs), 12);
      chki("bp_val_after", 32'(s_val), 0);
      for (int n = 0; n < 12; n++) chk($sformatf("bp_coef%0d", n), got[n], {3'b000, bp[n]});

      // back-to-back elements presented continuously
      acc1 = -1; acc2 = -1; sop1 = -1; sop2 = -1; eop1 = -1; eop2 = -1; nacc = 0;
      ctl_eop1 = '0; ctl_sop2 = '0;
      fe_dat = vecs[0].coef; fe_ctl = 8'h01; fe_val = 1'b1;
      for (int c = 0; c < 60 && eop2 < 0; c++) begin
         if (fe_val && fe_rdy) begin
            if (nacc == 0) acc1 = cyc + 1; else acc2 = cyc + 1;
            nacc++;
         end
         if (s_val && s_sop) begin
            if (sop1 < 0) sop1 = cyc; else begin sop2 = cyc; ctl_sop2 = s_ctl; end
         end
         if (s_val && s_eop) begin
            if (eop1 < 0) begin eop1 = cyc; ctl_eop1 = s_ctl; end else eop2 = cyc;
         end
         step;
         if (nacc == 1) begin fe_dat = vecs[3].coef; fe_ctl = 8'h02; end
         if (nacc >= 2) fe_val = 1'b0;
      end
      fe_val = 1'b0;
      chki("b2b_sop1", 32'(sop1 - acc1), 0);
      chki("b2b_eop1", 32'(eop1 - acc1), 11);
      chki("b2b_acc2", 32'(acc2 - acc1), SKID ? 32'd1 : 32'd13);
      chki("b2b_sop2", 32'(sop2 - acc1), SKID ? 32'd12 : 32'd13);
      chki("b2b_eop2", 32'(eop2 - sop2), 11);
      chki("b2b_ctl1", 32'(ctl_eop1), 32'h01);
      chki("b2b_ctl2", 32'(ctl_sop2), 32'h02);
      step;

      // reset mid-packet after beat 5 handshakes
      send_elem(vecs[2].coef, 8'h33);
      for (int b = 0; b < 5; b++) step;
      chk("mid_beat6", s_dat, vecs[2].exp_dat[5]);
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step;
         chki("mid_rst_val", 32'(s_val), 0); chki("mid_rst_rdy", 32'(fe_rdy), 0);
         chki("mid_rst_eop", 32'(s_eop), 0);
      end
      rst = 1'b1;
      step;
      chki("mid_rel_rdy", 32'(fe_rdy), 1); chki("mid_rel_val", 32'(s_val), 0);
      send_elem(vecs[0].coef, 8'h44);
      for (int b = 0; b < 12; b++) begin
         chki("mid_new_val", 32'(s_val), 1);
         chk($sformatf("mid_new_dat%0d", b), s_dat, vecs[0].exp_dat[b]);
         chki("mid_new_sop", 32'(s_sop), 32'(b == 0));
         chki("mid_new_eop", 32'(s_eop), 32'(b == 11));
         chki("mid_new_ctl", 32'(s_ctl), 32'h44);
         step;
      end
      chki("mid_new_end", 32'(s_val), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bls12_381_fe12_stream_tx.md
# bls12_381_fe12_stream_tx

Parallel-to-stream transmitter for Fp12 elements. It accepts one complete FE12 value (12 Fp coefficients) on a parallel valid/ready port and serializes it onto an `if_axi_stream` master as a 12-beat packet. The packet is the one the final-exponentiation and pairing engines consume. The block sits between result registers or host logic and any FE12 stream sink.

## Interface
- `FE_TYPE`, `bls12_381_pkg::fe_t`: Fp coefficient type, 381 bits.
- `CTL_BITS`, 8: width of the sideband control word carried with each element.
- `BEAT_BYTS`, 48: stream beat width in bytes. The coefficient occupies the low `$bits(FE_TYPE)` bits and the upper bits are 0.

Ports:
- `i_clk`, in, 1: clock.
- `i_rst`, in, 1: reset, synchronous, active-low.
- `i_fe12_val`, in, 1: parallel element valid.
- `i_fe12_dat`, in, 12*`$bits(FE_TYPE)`: element. Coefficient f[i][j][k] is at index n = i*6+j*2+k.
- `i_fe12_ctl`, in, `CTL_BITS`: control word for this element.
- `o_fe12_rdy`, out, 1: element accepted when `i_fe12_val` and `o_fe12_rdy` are both high.
- `o_stream_if`, if_axi_stream master, DAT_BYTS=`BEAT_BYTS`, CTL_BITS=`CTL_BITS`: fields val, dat, sop, eop, ctl, mod, err, rdy.

## Operation
- **States**
  - IDLE: no element held. `o_fe12_rdy`=1.
  - SEND: element held. Beat counter `cnt` (4 bits, 0..11) selects the coefficient.
- **IDLE → SEND** on accept:
  - Latch the element and its ctl.
  - Set `cnt`=0.
- **Beats in SEND**
  - Beat `cnt` carries coefficient n=`cnt`, zero-extended to `BEAT_BYTS`*8 bits.
  - sop=(cnt==0), eop=(cnt==11).
  - ctl = latched ctl on every beat. mod=0, err=0.
- **Beat advance**: on `o_stream_if.val && o_stream_if.rdy`, `cnt` increments.
- **Packet end**: on handshake with cnt==11, `cnt` returns to 0. The block goes to IDLE, or reloads from the skid entry (see Configuration).
- **Stall**: while `rdy`=0, val, dat, sop, eop and ctl are held unchanged. val never drops before its handshake.
- **Coefficients ≥ P**: transmitted unmodified. The block does not reduce them.
- **Reset**
  - While `i_rst`=0: o_stream_if.val=0, sop=0, eop=0, dat=0, ctl=0, mod=0, err=0, `o_fe12_rdy`=0, `cnt`=0, all buffers empty.
  - `o_fe12_rdy` goes to 1 on the first cycle after reset is released.
- **Reset mid-packet**: the packet is dropped with no eop, and both entries are discarded. After release, the next accepted element starts with sop.

## Timing
- Element accepted at edge N → first beat (sop) has val=1 after edge N, i.e. visible in cycle N+1. Latency is 1 cycle.
- With `rdy` held high, the 12 beats occupy 12 consecutive cycles. The eop beat is in cycle N+12.
- All outputs are registered. `o_fe12_rdy` has no combinational path from `o_stream_if.rdy`.
- **Without skid**:
  - `o_fe12_rdy`=1 only in IDLE.
  - IDLE is re-entered on the edge after the eop handshake.
  - The next element is accepted at the earliest at that cycle, so the minimum element period is 13 cycles.

## Configuration
- Macro: `BLS12_381_FE12_STREAM_TX_SKID_EN`.
- **Defined**: a second element register (skid entry) is added.
  - `o_fe12_rdy` = skid entry empty, so an element can be accepted during SEND.
  - On the eop handshake, a full skid entry moves to the active register. Its sop beat is then valid in the next cycle, with no bubble.
  - Sustained throughput is 1 element per 12 cycles.
  - Elements leave in acceptance order.
- **Undefined**: single register, behaviour as in Timing.

## Test plan
- **Single element**
  - Stimulus: f with coefficient n = n+1 (1..12), ctl=8'hA5, `rdy` tied high.
  - Response: beats 1..12 in cycles N+1..N+12; sop only on beat 1, eop only on beat 12; ctl=8'hA5 on all beats; mod=0.
- **Backpressure**
  - Stimulus: random vector (each coefficient mod P) with `rdy` toggling 1,0,0,1,…
  - Response: dat, sop, eop stable while `rdy`=0; reassembled f equals input; 12 handshakes exactly.
- **Back-to-back**
  - Stimulus: two elements (ctl 8'h01, 8'h02) presented continuously.
  - Response with macro: eop of element 1 in cycle N+12 and sop of element 2 in cycle N+13.
  - Response without macro: second accept occurs at cycle N+13, one idle cycle after the eop handshake, and its sop is in cycle N+14.
- **Reset mid-packet**
  - Stimulus: drive `i_rst`=0 for 2 cycles after beat 5 handshakes.
  - Response: val=0 and `o_fe12_rdy`=0 during reset; no eop for the aborted element; next element starts with sop carrying coefficient 0.
- **Unreduced coefficient**
  - Stimulus: coefficient 0 = `{381{1'b1}}`.
  - Response: beat 1 dat = 381 ones in the low bits with the upper bits 0. No error is flagged.
- **Loopback to FE12 receiver**
  - Stimulus: 10 random elements into the final-exponent engine's stream input.
  - Response: the engine's outputs match the software model `final_exponent()`.
